popcount_frame_acc: RTL

//   Downstream stage of the 4-bit ones-count LUT. Consumes one 3-bit nibble

---
 rtl/popcount_frame_acc.sv | 110 +++++++++++
 1 files changed

// File: rtl/popcount_frame_acc.sv
// Frame accumulator for the nibble popcount stream. It sums FRAME_NIBBLES saturated
// 0..4 counts into one total and holds that total on a valid/ready output.
module popcount_frame_acc #(
    parameter int unsigned FRAME_NIBBLES = 8,
    parameter int unsigned ACC_W         = 6,
    parameter int unsigned CNT_W         = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_count,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_total,
    output logic             out_err
);

    typedef enum logic [0:0] {StAcc, StHold} state_e;

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] total_q, total_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;

    logic [2:0]       sat_count;
    logic [ACC_W-1:0] sum;
    logic             accept;
    logic             last_beat;

    // rst_n is part of in_ready so no beat appears taken while reset is asserted.
    assign in_ready  = (state_q == StAcc) && !clear && rst_n;
    assign accept    = in_valid && in_ready;
    assign sat_count = (in_count > 3'd4) ? 3'd4 : in_count;
    assign sum       = acc_q + ACC_W'(sat_count);
    assign last_beat = (idx_q == CNT_W'(FRAME_NIBBLES - 1));

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        total_d = total_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        err_d   = err_q;

        // The error flag is sticky across frames and clear.
        if (accept && (in_count > 3'd4)) begin
            err_d = 1'b1;
        end

        if (clear) begin
            state_d = StAcc;
            acc_d   = '0;
            idx_d   = '0;
            valid_d = 1'b0;
        end else begin
            unique case (state_q)
                StAcc: begin
                    if (accept) begin
                        if (last_beat) begin
                            total_d = sum;
                            valid_d = 1'b1;
                            acc_d   = '0;
                            idx_d   = '0;
                            state_d = StHold;
                        end else begin
                            acc_d = sum;
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
                StHold: begin
                    if (out_ready) begin
                        valid_d = 1'b0;
                        state_d = StAcc;
                    end
                end
                default: begin
                    state_d = StAcc;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StAcc;
            acc_q   <= '0;
            total_q <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            total_q <= total_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign out_valid = valid_q;
    assign out_total = total_q;
    assign out_err   = err_q;

endmodule
